// File: rtl/ascii_result_encoder_if.sv
// Handshake bundle between the arithmetic core, the ASCII result encoder and the UART transmitter.
// The slave modport is the encoder; the master modport is whatever drives results and consumes chars.
interface ascii_result_encoder_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] result;
  logic             err;
  logic             i_ready;
  logic             tx_busy;
  logic [7:0]       char;
  logic             o_ready;
  logic             busy;

  modport master (
    output result, err, i_ready, tx_busy,
    input  char, o_ready, busy
  );

  modport slave (
    input  result, err, i_ready, tx_busy,
    output char, o_ready, busy
  );
endinterface

// File: rtl/ascii_result_encoder.sv
// Serialises one result word into ASCII: optional '-', decimal digits without leading zeros
// (or "ERR"), then a terminator, one character per o_ready strobe under tx_busy backpressure.
module ascii_result_encoder #(
  parameter int         WIDTH  = 16,
  parameter int         SIGNED = 1,
  parameter logic [7:0] TERM   = 8'h0A
) (
  input  logic                 clk,
  input  logic                 reset,
  ascii_result_encoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SIGN, CALC, EMIT, ERRS, TERMS} state_t;

  // Decimal place table; index 4 is the units place.
  function automatic logic [16:0] place_val(input logic [2:0] idx);
    case (idx)
      3'd0:    place_val = 17'd10000;
      3'd1:    place_val = 17'd1000;
      3'd2:    place_val = 17'd100;
      3'd3:    place_val = 17'd10;
      default: place_val = 17'd1;
    endcase
  endfunction

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mag, mag_nxt;
  logic [3:0]       digit, digit_nxt;
  logic [2:0]       idx, idx_nxt;
  logic             sent, sent_nxt;
  logic [1:0]       ecnt, ecnt_nxt;
  logic [7:0]       char_r, char_nxt;
  logic             ordy_r, ordy_nxt;
  logic             busy_r, busy_nxt;

  logic signed [WIDTH-1:0] res_s;
  logic                    neg;
  logic [WIDTH-1:0]        mag_abs;
  logic [16:0]             mag_ext;
  logic [16:0]             place;
  logic                    emit_ok;

  assign res_s   = $signed(bus.result);
  assign neg     = (SIGNED != 0) && (res_s < 0);
  // Negating the most negative value wraps back to 2^(WIDTH-1), which is its magnitude.
  assign mag_abs = neg ? WIDTH'(-res_s) : bus.result;
  assign mag_ext = 17'(mag);
  assign place   = place_val(idx);
  // A strobe always follows at least one idle cycle so the transmitter can raise tx_busy.
  assign emit_ok = !bus.tx_busy && !ordy_r;

  assign bus.char    = char_r;
  assign bus.o_ready = ordy_r;
  assign bus.busy    = busy_r;

  always_comb begin
    state_nxt = state;
    mag_nxt   = mag;
    digit_nxt = digit;
    idx_nxt   = idx;
    sent_nxt  = sent;
    ecnt_nxt  = ecnt;
    char_nxt  = 8'h00;
    ordy_nxt  = 1'b0;
    busy_nxt  = busy_r;
    case (state)
      IDLE: begin
        // busy is still high during the TERM strobe, which also blocks acceptance in that cycle.
        busy_nxt = 1'b0;
        if (bus.i_ready && !busy_r) begin
          busy_nxt  = 1'b1;
          digit_nxt = 4'd0;
          idx_nxt   = 3'd0;
          sent_nxt  = 1'b0;
          ecnt_nxt  = 2'd0;
          if (bus.err) begin
            state_nxt = ERRS;
          end else begin
            mag_nxt   = mag_abs;
            state_nxt = neg ? SIGN : CALC;
          end
        end
      end
      SIGN: begin
        if (emit_ok) begin
          char_nxt  = 8'h2D;
          ordy_nxt  = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (mag_ext >= place) begin
          mag_nxt   = WIDTH'(mag_ext - place);
          digit_nxt = digit + 4'd1;
        end else if (digit == 4'd0 && !sent && idx != 3'd4) begin
          idx_nxt = idx + 3'd1;
        end else begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (emit_ok) begin
          char_nxt  = 8'h30 + {4'b0000, digit};
          ordy_nxt  = 1'b1;
          digit_nxt = 4'd0;
          sent_nxt  = 1'b1;
          if (idx == 3'd4) begin
            state_nxt = TERMS;
          end else begin
            idx_nxt   = idx + 3'd1;
            state_nxt = CALC;
          end
        end
      end
      ERRS: begin
        if (emit_ok) begin
          char_nxt = (ecnt == 2'd0) ? 8'h45 : 8'h52;
          ordy_nxt = 1'b1;
          ecnt_nxt = ecnt + 2'd1;
          if (ecnt == 2'd2) state_nxt = TERMS;
        end
      end
      TERMS: begin
        if (emit_ok) begin
          char_nxt  = TERM;
          ordy_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mag    <= '0;
      digit  <= 4'd0;
      idx    <= 3'd0;
      sent   <= 1'b0;
      ecnt   <= 2'd0;
      char_r <= 8'h00;
      ordy_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      mag    <= mag_nxt;
      digit  <= digit_nxt;
      idx    <= idx_nxt;
      sent   <= sent_nxt;
      ecnt   <= ecnt_nxt;
      char_r <= char_nxt;
      ordy_r <= ordy_nxt;
      busy_r <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_ascii_result_encoder.sv
// Directed bench for ascii_result_encoder: captures every strobed character and compares
// each transmitted string against hand-written expected text.
module tb_ascii_result_encoder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ascii_result_encoder_if #(.WIDTH(16)) bus ();

  ascii_result_encoder #(
    .WIDTH (16),
    .SIGNED(1),
    .TERM  (8'h0A)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rx_q[$];
  logic       prev_ordy;
  logic       txb_at_edge;
  int         gap_viol;
  int         busy_viol;
  logic       term_busy;

  initial begin
    prev_ordy   = 1'b0;
    txb_at_edge = 1'b0;
    gap_viol    = 0;
    busy_viol   = 0;
    term_busy   = 1'b0;
  end

  always @(posedge clk) txb_at_edge <= bus.tx_busy;

  always @(negedge clk) begin
    if (bus.o_ready) begin
      rx_q.push_back(bus.char);
      if (prev_ordy) gap_viol++;
      if (txb_at_edge) busy_viol++;
      if (bus.char == 8'h0A) term_busy = bus.busy;
    end
    prev_ordy = bus.o_ready;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] r, input logic e);
    @(negedge clk);
    bus.result  = r;
    bus.err     = e;
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_str(input string tag, input string s);
    logic [7:0] exp;
    int         n;
    check({tag, "_len"}, rx_q.size(), s.len() + 1);
    n = (rx_q.size() < s.len() + 1) ? rx_q.size() : s.len() + 1;
    for (int i = 0; i < n; i++) begin
      exp = (i < s.len()) ? s[i] : 8'h0A;
      check($sformatf("%s[%0d]", tag, i), {24'd0, rx_q[i]}, {24'd0, exp});
    end
  endtask

  task automatic run_value(input string tag, input logic [15:0] r, input logic e, input string s);
    rx_q.delete();
    term_busy = 1'b0;
    send(r, e);
    wait_done(tag);
    check_str(tag, s);
  endtask

  initial begin
    int n;
    int n0;
    int n1;
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    bus.result  = '0;
    bus.err     = 1'b0;
    bus.i_ready = 1'b0;
    bus.tx_busy = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_char", {24'd0, bus.char}, 32'd0);
    check("rst_ordy", {31'd0, bus.o_ready}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_value("v43", 16'd43, 1'b0, "43");
    check("v43_term_busy", {31'd0, term_busy}, 32'd1);
    run_value("vm5", 16'hFFFB, 1'b0, "-5");
    run_value("vmin", 16'h8000, 1'b0, "-32768");
    run_value("vzero", 16'd0, 1'b0, "0");
    run_value("vmax", 16'h7FFF, 1'b0, "32767");
    run_value("v10000", 16'd10000, 1'b0, "10000");
    run_value("vm1", 16'hFFFF, 1'b0, "-1");
    run_value("verr", 16'd123, 1'b1, "ERR");

    // Backpressure: hold tx_busy for 20 cycles right after the '9' strobe.
    rx_q.delete();
    send(16'd907, 1'b0);
    n = 0;
    while (!bus.o_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("hold_first_seen", {31'd0, bus.o_ready}, 32'd1);
    bus.tx_busy = 1'b1;
    @(posedge clk);
    n0 = rx_q.size();
    repeat (20) @(posedge clk);
    n1 = rx_q.size();
    check("hold_no_strobe", n1 - n0, 32'd0);
    @(negedge clk);
    bus.tx_busy = 1'b0;
    wait_done("hold");
    check_str("hold", "907");

    // A second result arriving while busy is dropped.
    rx_q.delete();
    send(16'd907, 1'b0);
    repeat (3) @(negedge clk);
    check("drop_busy", {31'd0, bus.busy}, 32'd1);
    send(16'd5, 1'b0);
    wait_done("drop");
    repeat (30) @(negedge clk);
    check_str("drop", "907");

    // Asynchronous reset mid-stream, after '3' of 12345.
    rx_q.delete();
    send(16'd12345, 1'b0);
    n = 0;
    while (rx_q.size() < 3 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1 reset = 1'b0;
    #1;
    check("arst_ordy", {31'd0, bus.o_ready}, 32'd0);
    check("arst_char", {24'd0, bus.char}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_count", rx_q.size(), 32'd3);
    if (rx_q.size() >= 3) check("arst_last", {24'd0, rx_q[2]}, 32'h33);
    @(negedge clk);
    reset = 1'b1;
    rx_q.delete();
    repeat (30) @(negedge clk);
    check("arst_no_resume", rx_q.size(), 32'd0);
    run_value("after_rst", 16'd8, 1'b0, "8");

    check("gap_violations", gap_viol, 32'd0);
    check("txbusy_violations", busy_viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
